reflet_debug_receiver: RTL

- Downstream stage of the CPU debug UART transmitter. It deserialises the 8N1 UART byte stream carrying a working-register dump and reassembles the little-endian bytes into one wordsize-bit word.
- Used on a host-side or monitor FPGA and in system benches to recover debug values without a PC.
- Emits one valid pulse per completed word.

---
 rtl/reflet_debug_receiver_pkg.sv | 23 ++
 rtl/reflet_debug_rx_byte.sv | 131 +++++++++++++
 rtl/reflet_debug_receiver.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/reflet_debug_receiver_pkg.sv
// -----------------------------------------------------------------------------
// reflet_debug_receiver_pkg
// Shared constants, byte-receiver FSM encoding and a word-size helper for the
// debug UART receiver (reflet_debug_receiver and reflet_debug_rx_byte).
// -----------------------------------------------------------------------------
package reflet_debug_receiver_pkg;

    localparam int BITS_PER_BYTE     = 8;
    localparam int UART_DEFAULT_BAUD = 9600;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Number of bytes carried by one debug word.
    function automatic int bytes_per_word(input int w);
        return w / BITS_PER_BYTE;
    endfunction

endpackage

// File: rtl/reflet_debug_rx_byte.sv
// -----------------------------------------------------------------------------
// reflet_debug_rx_byte
// 8N1 UART byte receiver: 2-flop synchroniser plus a start/data/stop FSM that
// samples each bit at its midpoint.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   enable    in   when low, synchroniser, FSM and counters hold
//   rx        in   UART line (idle high), asynchronous to clk
//   data      out  received byte, LSB first on the line
//   byte_done out  one-cycle pulse (combinational) at a good stop-bit sample
//   byte_err  out  one-cycle pulse (combinational) at a bad stop-bit sample
//   active    out  high while the FSM is outside IDLE
// -----------------------------------------------------------------------------
module reflet_debug_rx_byte
    import reflet_debug_receiver_pkg::*;
#(
    parameter int BP = 104
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_done,
    output logic       byte_err,
    output logic       active
);

    localparam logic [15:0] BP_M1   = 16'(BP - 1);
    localparam logic [15:0] HALF_M1 = 16'((BP / 2) - 1);

    logic        rx_meta;
    logic        rxs;
    rx_state_t   state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_nxt;
    logic [7:0]  shift, shift_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else if (enable) begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
        end
    end

    // Payload shifter carries no control meaning, so it is left unreset.
    always_ff @(posedge clk) begin
        shift <= shift_nxt;
    end

    // The counter counts down to zero; the cycle it reads zero is the sample
    // point. START waits half a bit, DATA/STOP wait a full bit each.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        byte_done = 1'b0;
        byte_err  = 1'b0;
        if (enable) begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state_nxt = START;
                        cnt_nxt   = HALF_M1;
                    end
                end
                START: begin
                    if (cnt == 16'd0) begin
                        if (rxs) begin
                            state_nxt = IDLE;   // glitch, not a real start bit
                        end else begin
                            state_nxt = DATA;
                            cnt_nxt   = BP_M1;
                            bit_nxt   = 3'd0;
                        end
                    end else begin
                        cnt_nxt = cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == 16'd0) begin
                        shift_nxt = {rxs, shift[7:1]};
                        cnt_nxt   = BP_M1;
                        if (bit_idx == 3'd7) begin
                            state_nxt = STOP;
                        end else begin
                            bit_nxt = bit_idx + 3'd1;
                        end
                    end else begin
                        cnt_nxt = cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == 16'd0) begin
                        state_nxt = IDLE;
                        if (rxs) begin
                            byte_done = 1'b1;
                        end else begin
                            byte_err = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt - 16'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign data   = shift;
    assign active = (state != IDLE);

endmodule

// File: rtl/reflet_debug_receiver.sv
// -----------------------------------------------------------------------------
// reflet_debug_receiver
// Receives the CPU debug UART stream (8N1) and reassembles little-endian bytes
// into one wordsize-bit word, pulsing word_valid once per completed word.
//
// Optional feature: define REFLET_DEBUG_RX_TIMEOUT_EN to discard a partial word
// after timeout_bits bit periods of line idle between bytes.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   enable      in   when low, all state holds and no pulses are emitted
//   rx          in   UART line, idle high, asynchronous to clk
//   word_out    out  last completed word
//   word_valid  out  one-cycle pulse when word_out updates
//   busy        out  high from a start-bit detect until word completes/discards
//   frame_error out  one-cycle pulse on a bad stop bit
// -----------------------------------------------------------------------------
module reflet_debug_receiver
    import reflet_debug_receiver_pkg::*;
#(
    parameter int wordsize     = 16,
    parameter int clk_freq     = 1000000,
    parameter int baud_rate    = UART_DEFAULT_BAUD,
    parameter int timeout_bits = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                rx,
    output logic [wordsize-1:0] word_out,
    output logic                word_valid,
    output logic                busy,
    output logic                frame_error
);

    localparam int NB    = bytes_per_word(wordsize);
    localparam int BP    = clk_freq / baud_rate;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    if (((wordsize % BITS_PER_BYTE) != 0) || (wordsize < BITS_PER_BYTE) || (timeout_bits < 1)) begin : g_bad_param
        $error("reflet_debug_receiver: invalid wordsize or timeout_bits");
    end

    logic [7:0]          data;
    logic                byte_done;
    logic                byte_err;
    logic                active;
    logic [IDX_W-1:0]    idx;
    logic                busy_r;
    logic                timeout_hit;
    logic [wordsize-1:0] shadow;
    logic [wordsize-1:0] word_next;

    reflet_debug_rx_byte #(
        .BP(BP)
    ) u_rx_byte (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .rx       (rx),
        .data     (data),
        .byte_done(byte_done),
        .byte_err (byte_err),
        .active   (active)
    );

    // Shadow word with the incoming byte merged at its little-endian slot.
    always_comb begin
        word_next = shadow;
        word_next[int'(idx) * BITS_PER_BYTE +: BITS_PER_BYTE] = data;
    end

    always_ff @(posedge clk) begin
        if (enable && byte_done && (idx != LAST_IDX)) begin
            shadow <= word_next;
        end
    end

`ifdef REFLET_DEBUG_RX_TIMEOUT_EN
    localparam logic [31:0] TO_CYC = 32'(timeout_bits * BP);
    logic [31:0] idle_cnt;

    // Counts only while a word is partially assembled and the line is idle.
    assign timeout_hit = busy_r && !active && (idle_cnt == (TO_CYC - 32'd1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (enable) begin
            if (active || !busy_r || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 32'd1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_out    <= '0;
            word_valid  <= 1'b0;
            frame_error <= 1'b0;
            idx         <= '0;
            busy_r      <= 1'b0;
        end else begin
            word_valid  <= 1'b0;
            frame_error <= 1'b0;
            if (enable) begin
                if (byte_err) begin
                    frame_error <= 1'b1;
                    idx         <= '0;
                    busy_r      <= 1'b0;
                end else if (byte_done) begin
                    if (idx == LAST_IDX) begin
                        word_out   <= word_next;
                        word_valid <= 1'b1;
                        idx        <= '0;
                        busy_r     <= 1'b0;
                    end else begin
                        idx    <= idx + 1'b1;
                        busy_r <= 1'b1;
                    end
                end else if (timeout_hit) begin
                    idx    <= '0;
                    busy_r <= 1'b0;
                end
            end
        end
    end

    // busy_r spans the gaps between bytes; active covers each byte in flight,
    // which also makes busy rise the cycle after a start-bit detect.
    assign busy = busy_r | active;

endmodule
